// File: rtl/cmip_edge_pkg.sv
// Shared mode encodings and edge-qualification helper for the multi-channel edge detector.
// Latency: n/a (types and a pure function). Backpressure: none.
package cmip_edge_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_e;

    function automatic logic edge_qualify(edge_mode_e mode, logic rise, logic fall);
        case (mode)
            EDGE_RISE: return rise;
            EDGE_FALL: return fall;
            EDGE_BOTH: return rise | fall;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cmip_edge_chan.sv
// One channel: synchroniser, glitch filter, qualified edge pulse and sticky W1C pending flag.
// Latency: SYNC_STAGES + N cycles from capture to level/edge. Backpressure: none, sampled every cycle.
module cmip_edge_chan
    import cmip_edge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sig,
    input  logic [MODE_W-1:0] i_mode,
    input  logic [FILT_W-1:0] i_filt_len,
    input  logic              i_evt_clr,
    output logic              o_level,
    output logic              o_edge,
    output logic              o_evt_pend,
    output logic              o_evt_pend_nxt
);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

    logic              sync_s;
    logic [FILT_W-1:0] cnt_q, cnt_d;
    logic              level_q, level_d;
    logic              edge_q, edge_d;
    logic              pend_q, pend_d;
    logic              upd;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Counter is cleared at or before i_filt_len, so it cannot wrap; >= lets a lowered length act at once.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        upd     = 1'b0;
        if (sync_s == level_q) begin
            cnt_d = '0;
        end else if (cnt_q >= i_filt_len) begin
            level_d = sync_s;
            cnt_d   = '0;
            upd     = 1'b1;
        end else begin
            cnt_d = cnt_q + FILT_W'(1);
        end
        edge_d = edge_qualify(edge_mode_e'(i_mode), upd & sync_s, upd & ~sync_s);
        pend_d = (pend_q & ~i_evt_clr) | edge_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            edge_q  <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            sync_q[0] <= i_sig;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            cnt_q   <= cnt_d;
            level_q <= level_d;
            edge_q  <= edge_d;
            pend_q  <= pend_d;
        end
    end

    assign o_level        = level_q;
    assign o_edge         = edge_q;
    assign o_evt_pend     = pend_q;
    assign o_evt_pend_nxt = pend_d;

endmodule

// File: rtl/cmip_edge_detect_mch.sv
// CH-channel edge detector for asynchronous board inputs feeding the interrupt path.
// Latency: SYNC_STAGES + N cycles capture to pulse. Backpressure: none, sampled every cycle.
module cmip_edge_detect_mch
    import cmip_edge_pkg::*;
#(
    parameter int CH          = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [CH-1:0]        i_sig,
    input  logic [MODE_W*CH-1:0] i_mode,
    input  logic [FILT_W-1:0]    i_filt_len,
    input  logic [CH-1:0]        i_evt_clr,
    output logic [CH-1:0]        o_level,
    output logic [CH-1:0]        o_edge,
    output logic [CH-1:0]        o_evt_pend,
    output logic                 o_any_evt
);

    logic [CH-1:0] pend_nxt;
    logic          any_q;

    for (genvar c = 0; c < CH; c++) begin : g_chan
        cmip_edge_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_W      (FILT_W)
        ) u_chan (
            .i_clk          (i_clk),
            .i_rst          (i_rst),
            .i_sig          (i_sig[c]),
            .i_mode         (i_mode[MODE_W*c +: MODE_W]),
            .i_filt_len     (i_filt_len),
            .i_evt_clr      (i_evt_clr[c]),
            .o_level        (o_level[c]),
            .o_edge         (o_edge[c]),
            .o_evt_pend     (o_evt_pend[c]),
            .o_evt_pend_nxt (pend_nxt[c])
        );
    end

    // Built from next-state pending bits so it switches on the same edge as o_evt_pend.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            any_q <= 1'b0;
        end else begin
            any_q <= |pend_nxt;
        end
    end

    assign o_any_evt = any_q;

endmodule

// File: doc/cmip_edge_detect_mch.md
# cmip_edge_detect_mch

Multi-channel edge detector that generalises the single-bit, fixed-depth rise/fall synchroniser to CH channels. Each channel has configurable synchroniser depth, a runtime-programmable glitch filter, and a per-channel edge-select mode. Each channel produces a one-cycle edge pulse and a sticky pending flag with write-one-to-clear. It sits between asynchronous board-level inputs (triggers, encoder index, interlocks) and the acquisition control logic / register bank interrupt path.

## Interface
- CH, 8: number of independent channels, ≥1
- SYNC_STAGES, 2: synchroniser flops per channel, ≥1
- FILT_W, 4: width of the glitch-filter counter and of i_filt_len, ≥1

- i_clk  in  1  system clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_sig  in  CH  asynchronous input levels
- i_mode  in  2*CH  per-channel edge select, bits [2c+1:2c]: 00 off, 01 rise, 10 fall, 11 both
- i_filt_len  in  FILT_W  shared filter length N (cycles of stability beyond the first)
- i_evt_clr  in  CH  write-one-to-clear of o_evt_pend, one-cycle pulse per bit
- o_level  out  CH  filtered, synchronised level
- o_edge  out  CH  one-cycle pulse on a qualified edge
- o_evt_pend  out  CH  sticky pending flag per channel
- o_any_evt  out  1  OR of o_evt_pend

## Operation
- Reset (i_rst high at a clock edge) clears the following to 0: sync chains, filter counters, o_level, o_edge, o_evt_pend, o_any_evt. Reset has priority over all other activity, including a filter count in progress, which is discarded.
- Sync: s[0] <= i_sig; s[k] <= s[k-1]. The synchronised value is s[SYNC_STAGES-1].
- Filter, per channel, each cycle:
  - If sync == o_level, counter <= 0.
  - Else if counter >= i_filt_len, o_level <= sync and counter <= 0.
  - Else counter <= counter + 1.
  - The counter never wraps, because it is cleared at or before i_filt_len.
  - The >= comparison makes a lowered i_filt_len mid-count take effect on the next cycle.
  - N=0 means no filtering: one-cycle update.
- Glitch rejection: a sync pulse shorter than N+1 cycles never changes o_level.
- Edge qualification: it is registered in the same cycle o_level updates.
  - rise = update to 1; fall = update to 0.
  - o_edge <= (rise & mode[0]) | (fall & mode[1]).
  - Otherwise o_edge <= 0, so pulses last exactly one cycle.
- Mode 00 suppresses o_edge but not o_level. A mode change applies to the next update edge; no pending edges are remembered.
- Because o_level resets to 0, a high input at reset release reports a rise after the full latency.
- Sticky flag: o_evt_pend <= (o_evt_pend & ~i_evt_clr) | edge_next. A set and a clear in the same cycle leave the flag set (set wins).
- o_any_evt is registered: it is the OR of the next-state o_evt_pend, so it is coherent with o_evt_pend.

## Timing
- An i_sig change that is stable and captured at edge k reaches sync at edge k+SYNC_STAGES-1.
- o_level and o_edge change after edge k+SYNC_STAGES+N.
- o_evt_pend and o_any_evt are set at the same edge.
- Clear latency is 1 cycle.
- Defaults (SYNC_STAGES=2, N=0): 2 cycles from capture to pulse.
- Minimum spacing of reported edges per channel is N+1 cycles.
- All outputs are registered; there are no combinational input-to-output paths.
- Channels are fully independent: simultaneous edges on all channels each pulse in the same cycle.

## Structure
- Package cmip_edge_pkg holds:
  - the mode encodings: EDGE_OFF = 2'b00, EDGE_RISE = 2'b01, EDGE_FALL = 2'b10, EDGE_BOTH = 2'b11;
  - a localparam for the mode field width (2).
- Sub-module cmip_edge_chan holds one channel: sync chain, filter counter, level, edge and sticky flag.
- The top generates CH instances of cmip_edge_chan and registers the OR reduction for o_any_evt.
- The sync flops carry the ASYNC_REG attribute.

## Test plan
- Reset release with i_sig[0]=1, mode 01, N=0, SYNC_STAGES=2 -> o_edge[0] pulses once 2 cycles after the first capture; o_level[0]=1; o_evt_pend[0]=1; o_any_evt=1.
- N=3, 3-cycle high glitch on ch1 -> no o_level or o_edge change; a 4-cycle pulse -> rise pulse at capture+2+3, then fall pulse after a stable low.
- Ch2 mode 10, square wave with period 20 -> exactly one o_edge per falling edge, none on rising; ch3 mode 11 -> two pulses per period; ch4 mode 00 -> o_level toggles, o_edge stays 0.
- i_evt_clr[5] asserted in the same cycle as a new ch5 edge -> o_evt_pend[5] stays 1; a clear one cycle later -> 0; o_any_evt falls with the last pending bit.
- N lowered from 10 to 2 while the counter is at 5 -> o_level updates on the next cycle; i_rst asserted mid-count -> counter discarded, all outputs 0 the next cycle, no spurious o_edge.
- All 8 channels toggle simultaneously, mode 11 -> all o_edge bits high in one cycle, each exactly one cycle wide.
